// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: WIDTH-bit a+b+cin computed CHUNK bits per clock through a
// single CHUNK-bit slice, with the inter-slice carry held in a register.
// Valid/ready handshake on both sides; one operation in flight at a time.
// Optional feature macro: SEQ_ADDER_SUB_EN adds a 'sub' input (a-b when set).
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NCHUNK  = WIDTH / CHUNK;
  localparam int unsigned IDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned SLICE_W = CHUNK + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  // Reject configurations where the operand does not split into whole slices
  if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_cfg
    $error("seq_chunk_adder: WIDTH must be a nonzero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   b_eff_in;
  logic               cin_eff_in;
  logic               accept;
  logic               last_slice;
  logic [CHUNK-1:0]   slice_a;
  logic [CHUNK-1:0]   slice_b;
  logic [SLICE_W-1:0] slice_res;
  logic               in_ready_next;
  logic               out_valid_next;
  logic               busy_next;

  // Effective second operand and carry-in, folded in at capture time
  always_comb begin
    b_eff_in   = b;
    cin_eff_in = cin;
`ifdef SEQ_ADDER_SUB_EN
    if (sub) begin
      b_eff_in   = ~b;
      cin_eff_in = 1'b1;
    end
`endif
  end

  // One CHUNK-bit ripple slice selected by the current chunk index
  always_comb begin
    slice_a   = a_q[idx_q*CHUNK +: CHUNK];
    slice_b   = b_q[idx_q*CHUNK +: CHUNK];
    slice_res = SLICE_W'(slice_a) + SLICE_W'(slice_b) + SLICE_W'(carry_q);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and next values of the handshake flags
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_slice = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (idx_q == LAST_IDX) begin
          last_slice = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    in_ready_next  = (state_next == ST_IDLE);
    out_valid_next = (state_next == ST_DONE);
    busy_next      = (state_next != ST_IDLE);
  end

  // Registered handshake and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
      busy      <= busy_next;
    end
  end

  // Operand capture and per-slice accumulation of sum, carry and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b_eff_in;
      carry_q <= cin_eff_in;
      idx_q   <= '0;
    end else if (state == ST_RUN) begin
      sum[idx_q*CHUNK +: CHUNK] <= slice_res[CHUNK-1:0];
      carry_q <= slice_res[CHUNK];
      idx_q   <= idx_q + IDX_W'(1);
      if (last_slice) begin
        cout <= slice_res[CHUNK];
        ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                (slice_res[CHUNK-1] != a_q[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: a 16/4 instance and an 8/8 (single-slice) instance,
// each checked every cycle against a transaction-level model.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid0 = 1'b0, in_ready0, cin0 = 1'b0, sub0 = 1'b0;
  logic        out_valid0, out_ready0 = 1'b1, cout0, ovf0, busy0;
  logic [15:0] a0 = '0, b0 = '0, sum0;

  logic        in_valid1 = 1'b0, in_ready1, cin1 = 1'b0, sub1 = 1'b0;
  logic        out_valid1, out_ready1 = 1'b1, cout1, ovf1, busy1;
  logic [7:0]  a1 = '0, b1 = '0, sum1;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .cin(cin0),
`ifdef SEQ_ADDER_SUB_EN
    .sub(sub0),
`endif
    .out_valid(out_valid0), .out_ready(out_ready0), .sum(sum0),
    .cout(cout0), .ovf(ovf0), .busy(busy0));

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
`ifdef SEQ_ADDER_SUB_EN
    .sub(sub1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
    .cout(cout1), .ovf(ovf1), .busy(busy1));

  int n_chk = 0;
  int n_fail = 0;
  int ops1 = 0;

  typedef struct packed {
    logic        ov;
    logic        co;
    logic [31:0] s;
  } res_t;

  // mode: 0 waiting for operands, 1 computing (rem clocks left), 2 result held
  typedef struct {
    int   mode;
    int   rem;
    res_t exp;
  } mdl_t;

  mdl_t m0, m1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain arithmetic on w-bit operands
  function automatic res_t ref_add(input int w, input logic [31:0] x, input logic [31:0] y,
                                   input logic c, input logic sb);
    logic [31:0] mask, xm, ye;
    logic        ce;
    logic [63:0] tot;
    res_t        r;
    mask = (32'd1 << w) - 32'd1;
    xm   = x & mask;
    ye   = (sb ? ~y : y) & mask;
    ce   = sb ? 1'b1 : c;
    tot  = 64'(xm) + 64'(ye) + 64'(ce);
    r.s  = tot[31:0] & mask;
    r.co = tot[w];
    r.ov = (xm[w-1] == ye[w-1]) && (r.s[w-1] != xm[w-1]);
    return r;
  endfunction

  function automatic logic [31:0] rnd(input int w);
    logic [31:0] mask, v;
    mask = (32'd1 << w) - 32'd1;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = mask;
      2:       v = 32'd1 << (w - 1);
      3:       v = (32'd1 << (w - 1)) - 32'd1;
      default: v = $urandom;
    endcase
    return v & mask;
  endfunction

  // Compare one instance against the model, then advance the model over the next edge
  task automatic model_step(input string tag, input int w, input int n, inout mdl_t m,
                            input logic rdy, input logic vld, input logic bsy,
                            input logic [31:0] s, input logic co, input logic ov,
                            input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                            input logic ic, input logic isb, input logic ordy, output bit acc);
    acc = 1'b0;
    chk({tag, "_in_ready"},  32'(rdy), 32'(m.mode == 0));
    chk({tag, "_out_valid"}, 32'(vld), 32'(m.mode == 2));
    chk({tag, "_busy"},      32'(bsy), 32'(m.mode != 0));
    chk({tag, "_known"},     32'($isunknown({s, co, ov})), 32'd0);
    if (m.mode == 2) begin
      chk({tag, "_sum"},  s,        m.exp.s);
      chk({tag, "_cout"}, 32'(co),  32'(m.exp.co));
      chk({tag, "_ovf"},  32'(ov),  32'(m.exp.ov));
    end
    case (m.mode)
      0: if (iv) begin
        m.exp  = ref_add(w, ia, ib, ic, isb);
        m.rem  = n;
        m.mode = 1;
        acc    = 1'b1;
      end
      1: begin
        m.rem--;
        if (m.rem == 0) m.mode = 2;
      end
      default: if (ordy) m.mode = 0;
    endcase
  endtask

  // Per-cycle compare process, sampling on the falling edge
  always @(negedge clk) begin
    bit acc0, acc1;
    if (!rst_n) begin
      chk("rst0_in_ready", 32'(in_ready0), 32'd1);
      chk("rst0_out_valid", 32'(out_valid0), 32'd0);
      chk("rst0_busy", 32'(busy0), 32'd0);
      chk("rst0_res", {13'd0, ovf0, cout0, busy0, sum0}, 32'd0);
      chk("rst1_res", {21'd0, out_valid1, busy1, ovf1, cout1, sum1}, 32'd0);
      m0.mode = 0; m0.rem = 0; m0.exp = '0;
      m1.mode = 0; m1.rem = 0; m1.exp = '0;
    end else begin
      model_step("d0", 16, 4, m0, in_ready0, out_valid0, busy0, 32'(sum0), cout0, ovf0,
                 in_valid0, 32'(a0), 32'(b0), cin0, sub0, out_ready0, acc0);
      model_step("d1", 8, 1, m1, in_ready1, out_valid1, busy1, 32'(sum1), cout1, ovf1,
                 in_valid1, 32'(a1), 32'(b1), cin1, sub1, out_ready1, acc1);
      if (acc1) ops1++;
    end
  end

  // Directed operation on the 16-bit instance with literal expectations
  task automatic op0(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                     input logic xs, input logic [15:0] es, input logic ec,
                     input logic eo, input bit stall);
    int t;
    int cnt;
    out_ready0 = !stall;
    in_valid0 = 1'b1; a0 = xa; b0 = xb; cin0 = xc; sub0 = xs;
    t = 0;
    while (!in_ready0 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("op0_accept_wait", 32'(in_ready0), 32'd1);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    cnt = 0;
    while (!out_valid0 && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    chk("op0_latency", 32'(cnt), 32'd4);
    chk("op0_sum_lit", 32'(sum0), 32'(es));
    chk("op0_cout_lit", 32'(cout0), 32'(ec));
    chk("op0_ovf_lit", 32'(ovf0), 32'(eo));
    if (stall) begin
      repeat (10) begin
        in_valid0 = 1'($urandom_range(0, 1));
        a0 = 16'($urandom); b0 = 16'($urandom);
        @(posedge clk); #1;
        chk("hold_valid", 32'(out_valid0), 32'd1);
        chk("hold_in_ready", 32'(in_ready0), 32'd0);
        chk("hold_sum", 32'(sum0), 32'(es));
      end
      in_valid0 = 1'b0;
      out_ready0 = 1'b1;
    end
    @(posedge clk); #1;
    chk("op0_release_valid", 32'(out_valid0), 32'd0);
    chk("op0_release_ready", 32'(in_ready0), 32'd1);
    sub0 = 1'b0;
  endtask

  initial begin
    res_t r;
    m0.mode = 0; m0.rem = 0; m0.exp = '0;
    m1.mode = 0; m1.rem = 0; m1.exp = '0;

    // Hand-computed values that pin the reference function
    r = ref_add(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
    chk("pin_ffff", {r.ov, r.co, r.s[29:0]}, {2'b01, 30'h0});
    r = ref_add(16, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
    chk("pin_7fff", {r.ov, r.co, r.s[29:0]}, {2'b10, 30'h8000});
    r = ref_add(8, 32'h80, 32'h80, 1'b0, 1'b0);
    chk("pin_80_80", {r.ov, r.co, r.s[29:0]}, {2'b11, 30'h0});
    r = ref_add(16, 32'h0005, 32'h0007, 1'b0, 1'b1);
    chk("pin_sub", {r.ov, r.co, r.s[29:0]}, {2'b00, 30'hFFFE});

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    op0(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    op0(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    op0(16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 1'b0);
    op0(16'h00A5, 16'h0F0F, 1'b0, 1'b0, 16'h0FB4, 1'b0, 1'b0, 1'b1);

    // Abort mid-computation, then verify no stale carry leaks into the next op
    in_valid0 = 1'b1; a0 = 16'h1234; b0 = 16'h0FFF; cin0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid0), 32'd0);
    chk("abort_in_ready", 32'(in_ready0), 32'd1);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_sum", 32'(sum0), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cin0 = 1'b0;
    op0(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);

`ifdef SEQ_ADDER_SUB_EN
    op0(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    op0(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif

    // Single-slice instance: result one clock after acceptance
    begin
      int cnt;
      out_ready1 = 1'b1;
      in_valid1 = 1'b1; a1 = 8'h80; b1 = 8'h80; cin1 = 1'b0;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      cnt = 0;
      while (!out_valid1 && cnt < 20) begin
        @(posedge clk); #1; cnt++;
      end
      chk("op1_latency", 32'(cnt), 32'd1);
      chk("op1_res_lit", {22'd0, ovf1, cout1, sum1}, {22'd0, 2'b11, 8'h00});
      @(posedge clk); #1;
    end

    // Random traffic on both instances with free-running valid/ready
    ops1 = 0;
    repeat (6000) begin
      in_valid0  = 1'($urandom_range(0, 1));
      a0 = 16'(rnd(16)); b0 = 16'(rnd(16)); cin0 = 1'($urandom_range(0, 1));
      out_ready0 = ($urandom_range(0, 3) != 0);
      in_valid1  = 1'($urandom_range(0, 1));
      a1 = 8'(rnd(8)); b1 = 8'(rnd(8)); cin1 = 1'($urandom_range(0, 1));
      out_ready1 = ($urandom_range(0, 3) != 0);
`ifdef SEQ_ADDER_SUB_EN
      sub0 = 1'($urandom_range(0, 1));
      sub1 = 1'($urandom_range(0, 1));
`endif
      @(posedge clk); #1;
    end
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    out_ready0 = 1'b1; out_ready1 = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("ops1_count", 32'(ops1 >= 1000), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
